// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 multiplier (unpack / normalize / round-pack) with a global stall.
// Define FPMUL_ROUND_EN for round-to-nearest-even; otherwise the fraction is truncated.
module fp_mul_pipe #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] flp_a,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] flp_b,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out_result,
    output logic [3:0]                             out_flags
);
    localparam int E  = EXPONENT_WIDTH;
    localparam int M  = MANTISSA_WIDTH;
    localparam int W  = E + M + 1;
    localparam int XW = E + 2;
    localparam int PW = 2 * M + 2;
    localparam logic signed [XW-1:0] BIAS    = XW'((1 << (E - 1)) - 1);
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << E) - 1);
    localparam logic signed [XW-1:0] EXP_ONE = XW'(1);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;

    logic en;

    // Stage 1 registers
    logic                 s1_valid_q, s1_sign_q, s1_inv_q, s1_inf_q, s1_zero_q;
    logic signed [XW-1:0] s1_exp_q;
    logic [PW-1:0]        s1_prod_q;
    // Stage 2 registers
    logic                 s2_valid_q, s2_sign_q, s2_inv_q, s2_inf_q, s2_zero_q, s2_g_q, s2_s_q;
    logic signed [XW-1:0] s2_exp_q;
    logic [M-1:0]         s2_frac_q;
    // Output registers
    logic                 out_valid_q;
    logic [W-1:0]         out_result_q;
    logic [3:0]           out_flags_q;

    // S1 combinational
    logic [E-1:0]         a_exp, b_exp;
    logic [M-1:0]         a_frac, b_frac;
    logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic                 s1_sign_d, s1_inv_d, s1_inf_d, s1_zero_d;
    logic signed [XW-1:0] s1_exp_d;
    logic [PW-1:0]        s1_prod_d;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    always_comb begin
        a_exp     = flp_a[W-2:M];
        b_exp     = flp_b[W-2:M];
        a_frac    = flp_a[M-1:0];
        b_frac    = flp_b[M-1:0];
        a_zero    = (a_exp == '0);
        b_zero    = (b_exp == '0);
        a_inf     = (&a_exp) && (a_frac == '0);
        b_inf     = (&b_exp) && (b_frac == '0);
        a_nan     = (&a_exp) && (|a_frac);
        b_nan     = (&b_exp) && (|b_frac);
        s1_sign_d = flp_a[W-1] ^ flp_b[W-1];
        s1_inv_d  = a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
        s1_inf_d  = a_inf || b_inf;
        s1_zero_d = a_zero || b_zero;
        s1_exp_d  = XW'({2'b00, a_exp}) + XW'({2'b00, b_exp});
        s1_prod_d = PW'({1'b1, a_frac}) * PW'({1'b1, b_frac});
    end

    // S2 combinational
    logic                 s2_g_d, s2_s_d;
    logic [M-1:0]         s2_frac_d;
    logic signed [XW-1:0] s2_exp_d;

    always_comb begin
        if (s1_prod_q[PW-1]) begin
            s2_frac_d = s1_prod_q[2*M:M+1];
            s2_g_d    = s1_prod_q[M];
            s2_s_d    = |s1_prod_q[M-1:0];
            s2_exp_d  = s1_exp_q + EXP_ONE;
        end else begin
            s2_frac_d = s1_prod_q[2*M-1:M];
            s2_g_d    = s1_prod_q[M-1];
            s2_s_d    = |s1_prod_q[M-2:0];
            s2_exp_d  = s1_exp_q;
        end
    end

    // S3 combinational
    logic                 round_up;
    logic [M:0]           frac_rnd;
    logic [M-1:0]         frac_fin;
    logic signed [XW-1:0] exp_fin;
    logic [W-1:0]         out_result_d;
    logic [3:0]           out_flags_d;

    always_comb begin
`ifdef FPMUL_ROUND_EN
        round_up = s2_g_q && (s2_s_q || s2_frac_q[0]);
`else
        round_up = 1'b0;
`endif
        frac_rnd = {1'b0, s2_frac_q} + (M + 1)'(round_up);
        exp_fin  = s2_exp_q - BIAS;
        frac_fin = frac_rnd[M-1:0];
        if (frac_rnd[M]) begin
            frac_fin = '0;
            exp_fin  = exp_fin + EXP_ONE;
        end
        out_flags_d = 4'b0000;
        if (s2_inv_q) begin
            out_result_d   = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
            out_flags_d[3] = 1'b1;
        end else if (s2_inf_q) begin
            out_result_d = {s2_sign_q, {E{1'b1}}, {M{1'b0}}};
        end else if (s2_zero_q) begin
            out_result_d = {s2_sign_q, {(W-1){1'b0}}};
        end else if (exp_fin >= EXP_MAX) begin
            out_result_d = {s2_sign_q, {E{1'b1}}, {M{1'b0}}};
            out_flags_d  = 4'b0101;
        end else if (exp_fin <= EXP_ZERO) begin
            out_result_d = {s2_sign_q, {(W-1){1'b0}}};
            out_flags_d  = 4'b0011;
        end else begin
            out_result_d   = {s2_sign_q, exp_fin[E-1:0], frac_fin};
            out_flags_d[0] = s2_g_q || s2_s_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_inv_q     <= 1'b0;
            s1_inf_q     <= 1'b0;
            s1_zero_q    <= 1'b0;
            s1_exp_q     <= '0;
            s1_prod_q    <= '0;
            s2_valid_q   <= 1'b0;
            s2_sign_q    <= 1'b0;
            s2_inv_q     <= 1'b0;
            s2_inf_q     <= 1'b0;
            s2_zero_q    <= 1'b0;
            s2_g_q       <= 1'b0;
            s2_s_q       <= 1'b0;
            s2_exp_q     <= '0;
            s2_frac_q    <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
        end else if (en) begin
            s1_valid_q   <= in_valid;
            s1_sign_q    <= s1_sign_d;
            s1_inv_q     <= s1_inv_d;
            s1_inf_q     <= s1_inf_d;
            s1_zero_q    <= s1_zero_d;
            s1_exp_q     <= s1_exp_d;
            s1_prod_q    <= s1_prod_d;
            s2_valid_q   <= s1_valid_q;
            s2_sign_q    <= s1_sign_q;
            s2_inv_q     <= s1_inv_q;
            s2_inf_q     <= s1_inf_q;
            s2_zero_q    <= s1_zero_q;
            s2_g_q       <= s2_g_d;
            s2_s_q       <= s2_s_d;
            s2_exp_q     <= s2_exp_d;
            s2_frac_q    <= s2_frac_d;
            out_valid_q  <= s2_valid_q;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe (FP32): directed vectors, throughput, backpressure, reset mid-stream.
module tb_fp_mul_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] flp_a = '0;
    logic [31:0] flp_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    fp_mul_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .flp_a(flp_a), .flp_b(flp_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

`ifdef FPMUL_ROUND_EN
    localparam logic [31:0] TIE_RES = 32'h3FC00002;
`else
    localparam logic [31:0] TIE_RES = 32'h3FC00001;
`endif

    logic [31:0] va [0:14] = '{32'h40000000, 32'h40000000, 32'h3FC00000, 32'h3F800001, 32'h7F800000,
                               32'hFF800000, 32'h7F000000, 32'h00800000, 32'h40400000, 32'h3F000000,
                               32'hC0000000, 32'h7FC00001, 32'h00000000, 32'h00000001, 32'h3F800001};
    logic [31:0] vb [0:14] = '{32'h40000000, 32'h40400000, 32'h3FC00000, 32'h3FC00000, 32'h00000000,
                               32'h40000000, 32'h7F000000, 32'h00800000, 32'h40400000, 32'h40800000,
                               32'h40400000, 32'h3F800000, 32'hC0000000, 32'h40000000, 32'h3F800001};
    logic [31:0] vr [0:14] = '{32'h40800000, 32'h40C00000, 32'h40100000, TIE_RES,      32'h7FC00000,
                               32'hFF800000, 32'h7F800000, 32'h00000000, 32'h41100000, 32'h40000000,
                               32'hC0C00000, 32'h7FC00000, 32'h80000000, 32'h00000000, 32'h3F800002};
    logic [3:0]  vf [0:14] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h8, 4'h0, 4'h5, 4'h3,
                               4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h1};

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          stalled_prev = 1'b0;
    logic [31:0] held_res;
    logic [3:0]  held_flg;
    bit          acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive after the falling edge, sample 1ns later, well before the rising edge.
    task automatic step(input bit iv, input int idx, input bit ordy, input bit lat, output bit accepted);
        exp_t e;
        @(negedge clk);
        in_valid  = iv;
        flp_a     = va[idx];
        flp_b     = vb[idx];
        out_ready = ordy;
        #1;
        if (stalled_prev) begin
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_result", out_result, held_res);
            chk("stall_flags", {28'b0, out_flags}, {28'b0, held_flg});
        end
        if (out_valid && !out_ready)
            chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", {31'b0, out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result", out_result, e.res);
                chk("flags", {28'b0, out_flags}, {28'b0, e.flg});
                if (e.lat) chk("latency", cyc - e.cyc, 32'd3);
            end
        end
        accepted = iv && in_ready;
        if (accepted) sb.push_back('{vr[idx], vf[idx], cyc, lat});
        stalled_prev = out_valid && !out_ready;
        held_res     = out_result;
        held_flg     = out_flags;
        cyc++;
    endtask

    initial begin
        int sent;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_flags", {28'b0, out_flags}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Isolated basic products with latency check
        for (int k = 0; k < 2; k++) begin
            step(1'b1, k, 1'b1, 1'b1, acc);
            chk("basic_accept", {31'b0, acc}, 32'd1);
            repeat (4) step(1'b0, 0, 1'b1, 1'b0, acc);
        end
        chk("basic_drain", sb.size(), 32'd0);

        // Full table back-to-back, one result per cycle
        for (int k = 0; k < 15; k++) begin
            step(1'b1, k, 1'b1, 1'b1, acc);
            chk("tput_accept", {31'b0, acc}, 32'd1);
        end
        repeat (4) step(1'b0, 0, 1'b1, 1'b0, acc);
        chk("tput_drain", sb.size(), 32'd0);

        // Backpressure: 8 pairs, random out_ready
        sent = 0;
        for (int c = 0; c < 300 && (sent < 8 || sb.size() > 0); c++) begin
            step(sent < 8, (sent < 8) ? 7 + sent : 7, 1'($urandom_range(0, 1)), 1'b0, acc);
            if (acc) sent++;
        end
        chk("bp_sent", sent, 32'd8);
        chk("bp_drain", sb.size(), 32'd0);
        repeat (2) step(1'b0, 0, 1'b1, 1'b0, acc);

        // Reset with three results in flight
        for (int k = 0; k < 3; k++) step(1'b1, k, 1'b1, 1'b0, acc);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rst_result", out_result, 32'd0);
        chk("async_rst_flags", {28'b0, out_flags}, 32'd0);
        sb.delete();
        stalled_prev = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 0, 1'b1, 1'b0, acc);
            chk("post_rst_quiet", {31'b0, out_valid}, 32'd0);
        end
        step(1'b1, 8, 1'b1, 1'b1, acc);
        repeat (4) step(1'b0, 0, 1'b1, 1'b0, acc);
        chk("post_rst_drain", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
